// File: rtl/mem_pkg.sv
// Shared types and sizing for the matrix-1 read sequencer (mem_read_seq).
package mem_pkg;

    localparam int unsigned M_DEF     = 6;
    localparam int unsigned N_DEF     = 3;
    localparam int unsigned NUM_READS = M_DEF * M_DEF / N_DEF;
    localparam int unsigned ROW_W     = $clog2(M_DEF);
    localparam int unsigned COL_W     = $clog2(M_DEF / N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } addr_t;

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_read_seq_if.sv
// Handshake and address bus between the matrix-multiply FSM, mem_read_seq and the read pipeline.
// MEM_READ_SEQ_PERF_EN adds the stall_cycles performance counter.
interface mem_read_seq_if
    import mem_pkg::*;
#(
    parameter int unsigned M = M_DEF,
    parameter int unsigned N = N_DEF
);
    localparam int unsigned RW = cnt_w(M);
    localparam int unsigned CW = cnt_w(M / N);

    logic          start;
    logic          abort;
    logic          stall;
    logic [RW-1:0] row;
    logic [CW-1:0] column;
    logic          rd_en;
    logic          busy;
    logic          done;
`ifdef MEM_READ_SEQ_PERF_EN
    logic [15:0]   stall_cycles;

    modport master (
        input  start, abort, stall,
        output row, column, rd_en, busy, done, stall_cycles
    );
    modport slave (
        output start, abort, stall,
        input  row, column, rd_en, busy, done, stall_cycles
    );
`else
    modport master (
        input  start, abort, stall,
        output row, column, rd_en, busy, done
    );
    modport slave (
        output start, abort, stall,
        input  row, column, rd_en, busy, done
    );
`endif

endinterface

// File: rtl/seq_wrap_cnt.sv
// Enable-gated up-counter that wraps at MAX; carry_c flags the wrapping increment.
module seq_wrap_cnt #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         carry_c
);

    assign carry_c = en && (count == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= carry_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/mem_read_seq.sv
// Sweeps the matrix-1 read pipeline over all M*(M/N) addresses, then waits DRAIN cycles and pulses done.
// Optional MEM_READ_SEQ_PERF_EN adds a saturating stall_cycles counter.
module mem_read_seq
    import mem_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned M     = M_DEF,
    parameter int unsigned DRAIN = N + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_read_seq_if.master bus
);

    localparam int unsigned RW    = cnt_w(M);
    localparam int unsigned CW    = cnt_w(M / N);
    localparam int unsigned DRN_W = cnt_w(DRAIN);

    state_e           state;
    logic             rd_en_q;
    logic             busy_q;
    logic             done_q;
    logic [DRN_W-1:0] drain_cnt;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             abort_hit_c;
    logic             cnt_clr_c;
    logic             row_adv_c;
    logic             row_carry_c;
    logic             col_carry_c;

    // Every strobed read advances the address; abort or idle parks it at (0,0).
    always_comb begin
        abort_hit_c = bus.abort && ((state == ST_ISSUE) || (state == ST_DRAIN));
        cnt_clr_c   = abort_hit_c || (state == ST_IDLE);
        row_adv_c   = (state == ST_ISSUE) && rd_en_q && !bus.abort;
    end

    seq_wrap_cnt #(.W(RW), .MAX(M - 1)) u_row_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr_c),
        .en      (row_adv_c),
        .count   (row_q),
        .carry_c (row_carry_c)
    );

    seq_wrap_cnt #(.W(CW), .MAX((M / N) - 1)) u_col_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr_c),
        .en      (row_carry_c),
        .count   (col_q),
        .carry_c (col_carry_c)
    );

    // Sweep control FSM with registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_ISSUE;
                        busy_q  <= 1'b1;
                        rd_en_q <= !bus.stall;
                    end
                end
                ST_ISSUE: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (col_carry_c) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRN_W'(DRAIN - 1);
                    end else begin
                        rd_en_q <= !bus.stall;
                    end
                end
                ST_DRAIN: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (drain_cnt == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row    = row_q;
    assign bus.column = col_q;
    assign bus.rd_en  = rd_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

`ifdef MEM_READ_SEQ_PERF_EN
    logic [15:0] stall_cnt;

    // Stalled ISSUE cycles of the current sweep, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == ST_IDLE) && bus.start) begin
            stall_cnt <= '0;
        end else if ((state == ST_ISSUE) && bus.stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 16'(1);
        end
    end

    assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_mem_read_seq.sv
// Self-checking bench for mem_read_seq: scenario table plus address scoreboard, reset corner by hand.
module tb_mem_read_seq;
    import mem_pkg::*;

    localparam int unsigned M     = 6;
    localparam int unsigned N     = 3;
    localparam int unsigned DRAIN = N + 1;
    localparam int          LAST  = 23;

    typedef struct {
        string       name;
        int          stall_lo;
        int          stall_hi;
        int          abort_cyc;
        int          re_a;
        int          re_b;
        int          done_cyc;
        int          busy_hi;
        int          reads;
        logic [31:0] rd_mask;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    addr_t exp_q[$];
    vec_t  vt[5];

    mem_read_seq_if #(.M(M), .N(N)) bus ();

    mem_read_seq #(.N(N), .M(M), .DRAIN(DRAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic run_scn(input vec_t v);
        int    reads;
        addr_t got;
        addr_t exp;
        reads = 0;
        exp_q.delete();
        for (int c = 0; c < int'(M / N); c++)
            for (int r = 0; r < int'(M); r++)
                exp_q.push_back('{col: COL_W'(c), row: ROW_W'(r)});
        bus.start = 1'b1;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        for (int cyc = 1; cyc <= LAST; cyc++) begin
            @(posedge clk);
            #1;
            chk({v.name, ".rd_en"}, cyc, 32'(bus.rd_en), 32'(v.rd_mask[cyc]));
            chk({v.name, ".done"}, cyc, 32'(bus.done), 32'(cyc == v.done_cyc));
            if (cyc != v.done_cyc)
                chk({v.name, ".busy"}, cyc, 32'(bus.busy), 32'(cyc <= v.busy_hi));
`ifdef MEM_READ_SEQ_PERF_EN
            if (cyc == 1)
                chk({v.name, ".stall_clr"}, cyc, 32'(bus.stall_cycles), 32'd0);
`endif
            if (bus.rd_en) begin
                reads++;
                got = '{col: bus.column, row: bus.row};
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL %s.addr cyc=%0d got=%0h exp=<none>", v.name, cyc, got);
                end else begin
                    exp = exp_q.pop_front();
                    chk({v.name, ".addr"}, cyc, 32'(got), 32'(exp));
                end
            end
            bus.start = (cyc == v.re_a) || (cyc == v.re_b);
            bus.stall = (cyc >= v.stall_lo) && (cyc <= v.stall_hi);
            bus.abort = (cyc == v.abort_cyc);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        chk({v.name, ".reads"}, LAST, 32'(reads), 32'(v.reads));
        chk({v.name, ".idle_addr"}, LAST, 32'({bus.column, bus.row}), 32'd0);
`ifdef MEM_READ_SEQ_PERF_EN
        chk({v.name, ".stall_cycles"}, LAST, 32'(bus.stall_cycles),
            32'((v.stall_lo > 0) ? (v.stall_hi - v.stall_lo + 1) : 0));
`endif
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;

        vt[0] = '{"nominal", 0, -1, -1, -1, -1, 17, 16, 12, span(1, 12)};
        vt[1] = '{"stall",   4,  6, -1, -1, -1, 20, 19, 12, span(1, 4) | span(8, 15)};
        vt[2] = '{"restart", 0, -1, -1,  3, 15, 17, 16, 12, span(1, 12)};
        vt[3] = '{"abort",   0, -1,  7, -1, -1, -1,  7,  7, span(1, 7)};
        vt[4] = '{"after_abort", 0, -1, -1, -1, -1, 17, 16, 12, span(1, 12)};

        #2;
        chk("reset.rd_en", 0, 32'(bus.rd_en), 32'd0);
        chk("reset.busy",  0, 32'(bus.busy),  32'd0);
        chk("reset.done",  0, 32'(bus.done),  32'd0);
        chk("reset.addr",  0, 32'({bus.column, bus.row}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) run_scn(vt[i]);

        // Asynchronous reset in the middle of a sweep.
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("midrst.pre_rd_en", 9, 32'(bus.rd_en), 32'd1);
        chk("midrst.pre_addr",  9, 32'({bus.column, bus.row}), 32'({1'b1, 3'd2}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.rd_en", 9, 32'(bus.rd_en), 32'd0);
        chk("midrst.busy",  9, 32'(bus.busy),  32'd0);
        chk("midrst.done",  9, 32'(bus.done),  32'd0);
        chk("midrst.addr",  9, 32'({bus.column, bus.row}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst.hold_done", 10, 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_scn(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
